// File: rtl/cycle_sequencer_pkg.sv
// Shared control-unit definitions for the cycle sequencer.
//   seq_state_e         : sequencer states (FETCH=0, RUN=1, HALT=2)
//   N_STEPS_DEF         : default T-states per M-cycle
//   N_MCYCLES_DEF       : default maximum M-cycles per instruction
//   STEP_ONEHOT_FIRST   : first T-state vector
//   COUNT_ONEHOT_FIRST  : first M-cycle vector
package cycle_sequencer_pkg;

  localparam int N_STEPS_DEF   = 4;
  localparam int N_MCYCLES_DEF = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  localparam logic [3:0] STEP_ONEHOT_FIRST  = 4'b0001;
  localparam logic [7:0] COUNT_ONEHOT_FIRST = 8'b00000001;

endpackage

// File: rtl/cycle_sequencer_onehot_ring.sv
// Rotating one-hot register with synchronous clear and advance enable.
//   clk : clock
//   clr : synchronous clear to FIRST (dominates en)
//   en  : rotate left by one position
//   q   : one-hot ring value
module cycle_sequencer_onehot_ring #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] FIRST = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= FIRST;
    end else if (en) begin
      q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Control-unit cycle sequencer: generates one-hot T-state and M-cycle
// vectors for the decoder bank, qualifies the decoders, strobes IR loads,
// and handles the boot/wake fetch and HALT.
//   i_Clk, i_Reset_n : clock, synchronous active-low reset
//   i_CE, i_Stall    : advance when i_CE=1 and i_Stall=0
//   i_IR_Fetch       : current M-cycle is the instruction's last
//   i_Halt_Req       : enter HALT at the end of the current instruction
//   i_Int_Pending    : wakes the sequencer from HALT
//   o_Cycle_Step     : one-hot T-state
//   o_Cycle_Count    : one-hot M-cycle
//   o_Active/o_Fetch_Only/o_Halted : state decodes
//   o_IR_Load        : single-clock IR load strobe
//   o_Mcycle_End     : this clock completes an M-cycle
//   o_Seq_Error      : sticky overrun flag
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int N_STEPS   = N_STEPS_DEF,
  parameter int N_MCYCLES = N_MCYCLES_DEF
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_CE,
  input  logic                 i_Stall,
  input  logic                 i_IR_Fetch,
  input  logic                 i_Halt_Req,
  input  logic                 i_Int_Pending,
  output logic [N_STEPS-1:0]   o_Cycle_Step,
  output logic [N_MCYCLES-1:0] o_Cycle_Count,
  output logic                 o_Active,
  output logic                 o_Fetch_Only,
  output logic                 o_IR_Load,
  output logic                 o_Mcycle_End,
  output logic                 o_Halted,
  output logic                 o_Seq_Error
);

  localparam logic [N_STEPS-1:0]   STEP_FIRST  = N_STEPS'(STEP_ONEHOT_FIRST);
  localparam logic [N_MCYCLES-1:0] COUNT_FIRST = N_MCYCLES'(COUNT_ONEHOT_FIRST);

  seq_state_e             state_q, state_d;
  logic [N_MCYCLES-1:0]   count_q, count_d;
  logic                   err_q, err_d;
  logic                   ir_load;
  logic                   adv;
  logic                   mcycle_end;
  logic [N_STEPS-1:0]     step_q;

  // Reset gates the advance so no strobe escapes during a reset clock.
  assign adv        = i_Reset_n & i_CE & ~i_Stall;
  assign mcycle_end = adv & step_q[N_STEPS-1];

  cycle_sequencer_onehot_ring #(
    .WIDTH (N_STEPS),
    .FIRST (STEP_FIRST)
  ) u_step_ring (
    .clk (i_Clk),
    .clr (~i_Reset_n),
    .en  (adv),
    .q   (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    ir_load = 1'b0;
    if (mcycle_end) begin
      unique case (state_q)
        ST_FETCH: begin
          count_d = COUNT_FIRST;
          ir_load = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_IR_Fetch) begin
            // HALT's own opcode fetch is real, so the IR still loads.
            count_d = COUNT_FIRST;
            ir_load = 1'b1;
            state_d = i_Halt_Req ? ST_HALT : ST_RUN;
          end else if (count_q[N_MCYCLES-1]) begin
            // Overran the count without a decoder finishing: refetch.
            count_d = COUNT_FIRST;
            err_d   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            count_d = {count_q[N_MCYCLES-2:0], 1'b0};
          end
        end
        ST_HALT: begin
          count_d = COUNT_FIRST;
          if (i_Int_Pending) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          count_d = COUNT_FIRST;
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q <= ST_FETCH;
      count_q <= COUNT_FIRST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_Active      = (state_q == ST_RUN);
  assign o_Fetch_Only  = (state_q == ST_FETCH);
  assign o_Halted      = (state_q == ST_HALT);
  assign o_IR_Load     = ir_load;
  assign o_Mcycle_End  = mcycle_end;
  assign o_Seq_Error   = err_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Testbench for cycle_sequencer: scenario tasks compare the DUT against a
// behavioural model that tracks T-state index, M-cycle index and mode.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ce, stall, irf, halt_req, int_pend;
  logic [3:0] step;
  logic [7:0] count;
  logic       active, fetch_only, ir_load, mend, halted, seq_err;

  int n_cmp = 0;
  int n_fail = 0;

  localparam int MD_BOOT = 0;
  localparam int MD_EXEC = 1;
  localparam int MD_SLEEP = 2;

  int m_mode, m_t, m_mc;
  bit m_err;
  int cyc = 0;

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_CE          (ce),
    .i_Stall       (stall),
    .i_IR_Fetch    (irf),
    .i_Halt_Req    (halt_req),
    .i_Int_Pending (int_pend),
    .o_Cycle_Step  (step),
    .o_Cycle_Count (count),
    .o_Active      (active),
    .o_Fetch_Only  (fetch_only),
    .o_IR_Load     (ir_load),
    .o_Mcycle_End  (mend),
    .o_Halted      (halted),
    .o_Seq_Error   (seq_err)
  );

  function automatic logic [17:0] dut_vec();
    return {step, count, active, fetch_only, ir_load, mend, halted, seq_err};
  endfunction

  // Expected outputs from model state plus the inputs currently driven.
  function automatic logic [17:0] exp_vec();
    logic [3:0] s;
    logic [7:0] c;
    logic       e, ld;
    s  = 4'b0001 << m_t;
    c  = 8'b00000001 << m_mc;
    e  = rst_n && ce && !stall && (m_t == 3);
    ld = e && ((m_mode == MD_BOOT) || ((m_mode == MD_EXEC) && irf));
    return {s, c, (m_mode == MD_EXEC), (m_mode == MD_BOOT), ld, e,
            (m_mode == MD_SLEEP), m_err};
  endfunction

  // Advance one clock and step the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_mode = MD_BOOT; m_t = 0; m_mc = 0; m_err = 0;
    end else if (ce && !stall) begin
      if (m_t == 3) begin
        case (m_mode)
          MD_BOOT: begin m_mode = MD_EXEC; m_mc = 0; end
          MD_EXEC: begin
            if (irf) begin
              m_mc = 0;
              if (halt_req) m_mode = MD_SLEEP;
            end else if (m_mc == 7) begin
              m_mc = 0; m_err = 1; m_mode = MD_BOOT;
            end else begin
              m_mc = m_mc + 1;
            end
          end
          default: begin
            m_mc = 0;
            if (int_pend) m_mode = MD_BOOT;
          end
        endcase
      end
      m_t = (m_t + 1) % 4;
    end
    #1;
  endtask

  task automatic set_in(input bit r, input bit c, input bit s, input bit f,
                        input bit h, input bit i);
    rst_n = r; ce = c; stall = s; irf = f; halt_req = h; int_pend = i;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    got = dut_vec();
    n_cmp++;
    if (got !== 18'b0001_00000001_0_1_0_0_0_0) begin
      n_fail++;
      $display("FAIL reset_values got=%b want=%b", got, 18'b0001_00000001_0_1_0_0_0_0);
    end
    n_cmp++;
    if (got !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model got=%h want=%h", got, exp_vec());
    end
    tick();
  endtask

  task automatic test_fetch_tied();
    int loads = 0;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (ir_load === 1'b1) loads++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fetch_tied cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    // FETCH load at clock 4, then one RUN load every 4 clocks.
    n_cmp++;
    if (loads != 4) begin
      n_fail++;
      $display("FAIL fetch_tied_loads got=%0d want=4", loads);
    end
  endtask

  task automatic test_multi_mcycle();
    int loads = 0;
    for (int i = 0; i < 8 && !(m_mode == MD_EXEC && m_t == 0 && m_mc == 0); i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 36; i++) begin
      set_in(1'b1, 1'b1, 1'b0, (m_mc == 2), 1'b0, 1'b0);
      @(negedge clk);
      if (ir_load === 1'b1) loads++;
      n_cmp++;
      if (dut_vec() !== exp_vec() || active !== 1'b1) begin
        n_fail++;
        $display("FAIL multi_mcycle cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    n_cmp++;
    if (loads != 3) begin
      n_fail++;
      $display("FAIL multi_mcycle_loads got=%0d want=3", loads);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 20 && !(m_mode == MD_EXEC && m_mc == 1 && m_t == 2); i++) begin
      set_in(1'b1, 1'b1, 1'b0, (m_mc == 2), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec() || step !== 4'b0100 || count !== 8'b00000010 || mend !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (step !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_release got=%b want=0100", step);
    end
    tick();
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), (m_mc == 2), 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_random cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_entry cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    for (int i = 0; i < 20 && m_t != 3; i++) begin
      set_in(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec() || halted !== 1'b1 || active !== 1'b0 || count !== 8'b00000001) begin
        n_fail++;
        $display("FAIL halt_hold cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (i == 0));
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_wake cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL overrun cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    for (int i = 0; i < 30; i++) begin
      set_in(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec() || seq_err !== 1'b1) begin
        n_fail++;
        $display("FAIL overrun_sticky cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100 && !(m_mode == MD_EXEC && m_mc == 2 && m_t == 1); i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (step !== 4'b0010 || count !== 8'b00000100) begin
      n_fail++;
      $display("FAIL reset_mid_setup got=%b/%b want=0010/00000100", step, count);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dut_vec() !== 18'b0001_00000001_0_1_0_0_0_0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid got=%b want=%b", dut_vec(), 18'b0001_00000001_0_1_0_0_0_0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      @(negedge clk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    m_mode = MD_BOOT; m_t = 0; m_mc = 0; m_err = 0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_fetch_tied();
    test_multi_mcycle();
    test_stall();
    test_halt();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
